// File: rtl/rank_filter_pkg.sv
// Shared constants and helpers for the rank filter path.
// Also used by the line buffer for the default pixel width and window side.
package rank_filter_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_K      = 5;

  localparam int RANK_MIN   = 0;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Median rank of an n-element window.
  function automatic int rank_med(input int n);
    return n / 2;
  endfunction

  // Maximum rank of an n-element window.
  function automatic int rank_max(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rank_count.sv
// Combinational rank of element IDX within a flattened window.
// Ties are broken by element index, so that the ranks of all elements
// form a permutation of 0..N-1.
module rank_count
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_K * DEF_K,
  parameter int IDX    = 0,
  parameter int RANK_W = 5
) (
  input  logic [N*DATA_W-1:0] window_i,
  output logic [RANK_W-1:0]   count_o
);

  logic [DATA_W-1:0] w_self;
  assign w_self = window_i[IDX*DATA_W +: DATA_W];

  // Count elements that sort strictly before this one.
  always_comb begin
    count_o = '0;
    for (int j = 0; j < N; j++) begin
      if (j != IDX) begin
        if ((window_i[j*DATA_W +: DATA_W] < w_self) ||
            ((window_i[j*DATA_W +: DATA_W] == w_self) && (j < IDX))) begin
          count_o = count_o + RANK_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rank_filter_calc.sv
// Pipelined KxK rank-order filter: one window per cycle, 3-cycle latency.
// Optional macro RANK_FILTER_ADAPTIVE_EN: pass the centre pixel through
// unless it is an extreme of its window (impulse), else use the ranked value.
module rank_filter_calc
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int RANK_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [K*K*DATA_W-1:0] window_i,
  input  logic [RANK_W-1:0]     rank_i,
  output logic [DATA_W-1:0]     median_o,
  output logic                  done_o,
  output logic                  rank_err_o
);

  localparam int N   = K * K;
  localparam int CTR = rank_med(N);
  localparam logic [RANK_W-1:0] RANK_CLAMP = RANK_W'(rank_max(N));

  // Stage 1
  logic                v1_q;
  logic [N*DATA_W-1:0] win1_q;
  logic [RANK_W-1:0]   rank1_q, rank1_d;
  logic                err1_q, err1_d;

  // Stage 2
  logic                v2_q;
  logic [N*DATA_W-1:0] win2_q;
  logic [RANK_W-1:0]   rank2_q;
  logic                err2_q;
  logic [RANK_W-1:0]   cnt_d  [N];
  logic [RANK_W-1:0]   cnt2_q [N];

  // Stage 3
  logic [DATA_W-1:0]   ranked_d;
  logic [DATA_W-1:0]   median_d;

  // Clamp an out-of-range rank to the maximum and flag it.
  always_comb begin
    err1_d  = (int'(rank_i) >= N);
    rank1_d = err1_d ? RANK_CLAMP : rank_i;
  end

  // Valid chain and output registers; cleared immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      done_o     <= 1'b0;
      median_o   <= '0;
      rank_err_o <= 1'b0;
    end else begin
      v1_q   <= done_i;
      v2_q   <= v1_q;
      done_o <= v2_q;
      if (v2_q) begin
        median_o   <= median_d;
        rank_err_o <= err2_q;
      end
    end
  end

  // Data path registers, loaded only alongside a valid window.
  always_ff @(posedge clk) begin
    if (done_i) begin
      win1_q  <= window_i;
      rank1_q <= rank1_d;
      err1_q  <= err1_d;
    end
    if (v1_q) begin
      win2_q  <= win1_q;
      rank2_q <= rank1_q;
      err2_q  <= err1_q;
      cnt2_q  <= cnt_d;
    end
  end

  // One rank counter per window element.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cnt
      rank_count #(
        .DATA_W (DATA_W),
        .N      (N),
        .IDX    (gi),
        .RANK_W (RANK_W)
      ) u_cnt (
        .window_i (win1_q),
        .count_o  (cnt_d[gi])
      );
    end
  endgenerate

  // One-hot select of the element whose rank matches, OR-reduced.
  always_comb begin
    ranked_d = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt2_q[i] == rank2_q) ranked_d = ranked_d | win2_q[i*DATA_W +: DATA_W];
    end
  end

`ifdef RANK_FILTER_ADAPTIVE_EN
  logic has_lt_d, has_gt_d, has_lt_q, has_gt_q;

  // Does the centre have neighbours on both sides of its value?
  always_comb begin
    has_lt_d = 1'b0;
    has_gt_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (win1_q[i*DATA_W +: DATA_W] < win1_q[CTR*DATA_W +: DATA_W]) has_lt_d = 1'b1;
      if (win1_q[i*DATA_W +: DATA_W] > win1_q[CTR*DATA_W +: DATA_W]) has_gt_d = 1'b1;
    end
  end

  // Carry the impulse flags with the window into stage 2.
  always_ff @(posedge clk) begin
    if (v1_q) begin
      has_lt_q <= has_lt_d;
      has_gt_q <= has_gt_d;
    end
  end

  // A centre bracketed by neighbours is kept; an extreme centre is replaced.
  always_comb begin
    median_d = (has_lt_q && has_gt_q) ? win2_q[CTR*DATA_W +: DATA_W] : ranked_d;
  end
`else
  assign median_d = ranked_d;
`endif

endmodule

// File: tb/tb_rank_filter_calc.sv
// Directed bench for rank_filter_calc: one K=5 and one K=3 instance.
module tb_rank_filter_calc;
  import rank_filter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         done5, done3;
  logic [199:0] win5;
  logic [71:0]  win3;
  logic [4:0]   rank5, rank3;
  logic [7:0]   med [2];
  logic         dn  [2];
  logic         er  [2];

  rank_filter_calc #(.DATA_W(8), .K(5), .RANK_W(5)) u_dut5 (
    .clk(clk), .rst(rst), .done_i(done5), .window_i(win5), .rank_i(rank5),
    .median_o(med[0]), .done_o(dn[0]), .rank_err_o(er[0])
  );

  rank_filter_calc #(.DATA_W(8), .K(3), .RANK_W(5)) u_dut3 (
    .clk(clk), .rst(rst), .done_i(done3), .window_i(win3), .rank_i(rank3),
    .median_o(med[1]), .done_o(dn[1]), .rank_err_o(er[1])
  );

  typedef int a25_t[25];
  typedef int a9_t[9];

  typedef struct {
    bit           k3;
    int           gap;
    logic [199:0] win;
    int           rank;
    int           ex;   // ranked-element result
    int           ad;   // result with the adaptive centre bypass
    bit           err;
  } vec_t;

  typedef struct {
    int         issue;
    logic [7:0] med;
    logic       err;
  } exp_t;

  exp_t       q [2][$];
  vec_t       vt[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] last_med [2];
  logic       last_err [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, want);
    end
  endtask

  function automatic logic [199:0] pk25(input a25_t a);
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) r[i*8 +: 8] = 8'(a[i]);
    return r;
  endfunction

  function automatic logic [199:0] pk9(input a9_t a);
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'(a[i]);
    return r;
  endfunction

  function automatic vec_t mkv(input bit k3, input int gap, input logic [199:0] w,
                               input int rank, input int ex, input int ad, input bit err);
    vec_t v;
    v.k3 = k3; v.gap = gap; v.win = w; v.rank = rank;
    v.ex = ex; v.ad = ad; v.err = err;
    return v;
  endfunction

  task automatic idle();
    done5 = 1'b0;
    done3 = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    int   u;
    idle();
    if (v.k3) begin
      done3 = 1'b1; win3 = v.win[71:0]; rank3 = 5'(v.rank); u = 1;
    end else begin
      done5 = 1'b1; win5 = v.win; rank5 = 5'(v.rank); u = 0;
    end
    e.issue = cyc;
`ifdef RANK_FILTER_ADAPTIVE_EN
    e.med = 8'(v.ad);
`else
    e.med = 8'(v.ex);
`endif
    e.err = v.err;
    q[u].push_back(e);
  endtask

  // Output monitor: every done_o must match the oldest outstanding window,
  // and outputs must hold while done_o is low.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (dn[u]) begin
        if (q[u].size() == 0) begin
          chk($sformatf("spurious_done_u%0d", u), 1, 0);
        end else begin
          exp_t e;
          e = q[u].pop_front();
          $display("txn u%0d cyc=%0d med=%0d want=%0d err=%0d want=%0d lat=%0d",
                   u, cyc, med[u], e.med, er[u], e.err, cyc - e.issue);
          chk($sformatf("latency_u%0d", u), cyc - e.issue, 3);
          chk($sformatf("median_u%0d", u), int'(med[u]), int'(e.med));
          chk($sformatf("rank_err_u%0d", u), int'(er[u]), int'(e.err));
          last_med[u] = e.med;
          last_err[u] = e.err;
        end
      end else begin
        chk($sformatf("hold_med_u%0d", u), int'(med[u]), int'(last_med[u]));
        chk($sformatf("hold_err_u%0d", u), int'(er[u]), int'(last_err[u]));
      end
    end
  end

  initial begin
    a25_t sh, all7, split;
    a9_t  wa, wb, wc;

    last_med[0] = '0; last_med[1] = '0;
    last_err[0] = 1'b0; last_err[1] = 1'b0;
    idle();
    win5 = '0; win3 = '0; rank5 = '0; rank3 = '0;

    sh = '{17, 3, 22, 9, 1, 25, 11, 6, 19, 14, 2, 20, 13, 8, 24, 5, 16, 10, 23, 7, 12, 4, 21, 15, 18};
    for (int i = 0; i < 25; i++) begin
      all7[i]  = 7;
      split[i] = (i < 12) ? 10 : 200;
    end
    wa = '{9, 3, 5, 1, 8, 2, 7, 4, 6};
    wb = '{10, 12, 11, 13, 255, 9, 14, 10, 12};
    wc = '{10, 12, 11, 13, 11, 9, 14, 10, 12};

    //              k3 gap window     rank           ex   ad   err
    vt.push_back(mkv(0, 0, pk25(sh),    rank_med(25),  13,  13, 0));
    vt.push_back(mkv(0, 0, pk25(sh),    RANK_MIN,       1,  13, 0));
    vt.push_back(mkv(0, 0, pk25(sh),    rank_max(25),  25,  13, 0));
    vt.push_back(mkv(0, 2, pk25(all7),  12,             7,   7, 0));
    vt.push_back(mkv(0, 0, pk25(split), 12,           200, 200, 0));
    vt.push_back(mkv(0, 0, pk25(split), 11,            10,  10, 0));
    vt.push_back(mkv(0, 1, pk25(sh),    25,            25,  13, 1));
    vt.push_back(mkv(0, 0, pk25(sh),    30,            25,  13, 1));
    vt.push_back(mkv(1, 0, pk9(wa),     4,              5,   8, 0));
    vt.push_back(mkv(1, 0, pk9(wa),     15,             9,   8, 1));
    vt.push_back(mkv(1, 0, pk9(wa),     8,              9,   8, 0));
    vt.push_back(mkv(1, 3, pk9(wa),     9,              9,   8, 1));
    vt.push_back(mkv(1, 0, pk9(wb),     4,             12,  12, 0));
    vt.push_back(mkv(1, 0, pk9(wc),     4,             11,  11, 0));
    vt.push_back(mkv(1, 0, pk9(wc),     0,              9,  11, 0));
    vt.push_back(mkv(1, 0, pk9(wb),     0,              9,   9, 0));

    // Reset state
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_done_u%0d", u), int'(dn[u]), 0);
      chk($sformatf("reset_med_u%0d", u), int'(med[u]), 0);
      chk($sformatf("reset_err_u%0d", u), int'(er[u]), 0);
    end
    @(negedge clk) rst = 1'b1;

    // Directed vectors, back to back except where a gap is requested
    for (int i = 0; i < vt.size(); i++) begin
      repeat (vt[i].gap) begin
        @(posedge clk); #1; idle();
      end
      @(posedge clk); #1;
      drive(vt[i]);
    end
    @(posedge clk); #1; idle();
    repeat (6) @(posedge clk);
    chk("drain_u0", q[0].size(), 0);
    chk("drain_u1", q[1].size(), 0);

    // Twenty back-to-back windows, then a reset with two still in flight
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(mkv(0, 0, pk25(sh), i, i + 1, 13, 0));
    end
    @(posedge clk); #1; idle();
    @(negedge clk); #1;
    rst = 1'b0;
    chk("inflight_at_reset", q[0].size(), 2);
    q[0].delete();
    last_med[0] = '0; last_med[1] = '0;
    last_err[0] = 1'b0; last_err[1] = 1'b0;
    #1;
    chk("async_clear_done", int'(dn[0]), 0);
    chk("async_clear_med", int'(med[0]), 0);
    chk("async_clear_err", int'(er[0]), 0);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    drive(mkv(0, 0, pk25(sh), 12, 13, 13, 0));
    @(posedge clk); #1; idle();
    repeat (6) @(posedge clk);
    chk("post_reset_drain_u0", q[0].size(), 0);
    chk("post_reset_drain_u1", q[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
